reg_scoreboard_ctrl: RTL and testbench

Issue-side scoreboard controller for the 32-entry register busy-flag table in the pipelined core. Marks a destination register busy when an instruction issues, clears it on writeback, and holds issue off on RAW/WAW hazards against in-flight writes. Also provides a drain sequence that blocks new issues until all outstanding writes retire, used ahead of exceptions and pipeline flushes.

---
 rtl/reg_scoreboard_ctrl_if.sv | 52 +++++
 rtl/reg_scoreboard_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_scoreboard_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_ctrl_if.sv
// Issue / writeback / drain bundle between decode and the register scoreboard.
// The scoreboard sits on the slave side; decode and writeback drive the master side.
interface reg_scoreboard_ctrl_if #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
);
    logic                issue_valid;
    logic                issue_ready;
    logic [ADDR_W-1:0]   issue_rs1;
    logic [ADDR_W-1:0]   issue_rs2;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_rd_we;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic                drain_req;
    logic                drain_done;
    logic [NUM_REGS-1:0] busy_flags;
    logic [ADDR_W:0]     outstanding;
    logic                wb_err;

    modport master (
        output issue_valid,
        output issue_rs1,
        output issue_rs2,
        output issue_rd,
        output issue_rd_we,
        output wb_valid,
        output wb_rd,
        output drain_req,
        input  issue_ready,
        input  drain_done,
        input  busy_flags,
        input  outstanding,
        input  wb_err
    );

    modport slave (
        input  issue_valid,
        input  issue_rs1,
        input  issue_rs2,
        input  issue_rd,
        input  issue_rd_we,
        input  wb_valid,
        input  wb_rd,
        input  drain_req,
        output issue_ready,
        output drain_done,
        output busy_flags,
        output outstanding,
        output wb_err
    );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Register busy-flag scoreboard: RAW/WAW issue interlock, writeback clear,
// and a drain sequence that blocks issue until all pending writes retire.
module reg_scoreboard_ctrl #(
    parameter int NUM_REGS           = 32,
    parameter int ADDR_W             = 5,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_scoreboard_ctrl_if.slave bus
);

    localparam bit HW_ZERO = (ZERO_REG_HARDWIRED != 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic [ADDR_W:0]       r_cnt;
    logic [ADDR_W:0]       w_cnt_nxt;
    logic                  r_wb_err;

    logic [NUM_REGS-1:0]   w_one;
    logic [NUM_REGS-1:0]   w_wb_vec;
    logic [NUM_REGS-1:0]   w_set_vec;
    logic [NUM_REGS-1:0]   w_eff;
    logic                  w_wb_en;
    logic                  w_wb_hit;
    logic                  w_clr;
    logic                  w_wb_bad;
    logic                  w_rs1_ok;
    logic                  w_rs2_ok;
    logic                  w_rd_ok;
    logic                  w_hazard;
    logic                  w_run;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_set;
    logic                  w_drain_done;

    assign w_one = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // r0 writebacks and operands are ignored entirely when r0 is hardwired
    assign w_rs1_ok = !(HW_ZERO && bus.issue_rs1 == '0);
    assign w_rs2_ok = !(HW_ZERO && bus.issue_rs2 == '0);
    assign w_rd_ok  = !(HW_ZERO && bus.issue_rd == '0);
    assign w_wb_en  = bus.wb_valid && !(HW_ZERO && bus.wb_rd == '0);

    assign w_wb_vec = w_wb_en ? (w_one << bus.wb_rd) : '0;
    assign w_wb_hit = r_busy[bus.wb_rd];
    assign w_clr    = w_wb_en & w_wb_hit;
    assign w_wb_bad = w_wb_en & ~w_wb_hit;

    // same-cycle writeback bypasses the flag so dependents issue in the wb cycle
    assign w_eff = r_busy & ~w_wb_vec;

    assign w_hazard = (w_rs1_ok & w_eff[bus.issue_rs1])
                    | (w_rs2_ok & w_eff[bus.issue_rs2])
                    | (w_rd_ok & bus.issue_rd_we & w_eff[bus.issue_rd]);

    assign w_ready   = w_run & ~w_hazard;
    assign w_accept  = bus.issue_valid & w_ready;
    assign w_set     = w_accept & bus.issue_rd_we & w_rd_ok;
    assign w_set_vec = w_set ? (w_one << bus.issue_rd) : '0;

    // set applied after clear so a same-register issue wins over its writeback
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt = w_busy_nxt & ~w_wb_vec;
        end
        w_busy_nxt = w_busy_nxt | w_set_vec;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_set, w_clr})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= '0;
            r_cnt    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_wb_bad) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (bus.drain_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.drain_req) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == 1 && w_clr) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.drain_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_run        = 1'b0;
        w_drain_done = 1'b0;
        unique case (r_state)
            ST_RUN:   w_run        = 1'b1;
            ST_DONE:  w_drain_done = 1'b1;
            default: begin
                w_run        = 1'b0;
                w_drain_done = 1'b0;
            end
        endcase
    end

    assign bus.issue_ready = w_ready;
    assign bus.drain_done  = w_drain_done;
    assign bus.busy_flags  = r_busy;
    assign bus.outstanding = r_cnt;
    assign bus.wb_err      = r_wb_err;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Directed bench for reg_scoreboard_ctrl: hazards, bypass, r0, drain, wb errors.
// Inputs change 1ns after the rising edge; outputs are checked in the same window.
module tb_reg_scoreboard_ctrl;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    reg_scoreboard_ctrl_if #(.ADDR_W(5), .NUM_REGS(32)) bus ();

    reg_scoreboard_ctrl #(
        .NUM_REGS(32),
        .ADDR_W(5),
        .ZERO_REG_HARDWIRED(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_rd    = '0;
        bus.issue_rd_we = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd, input bit we);
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = 5'(rs1);
        bus.issue_rs2   = 5'(rs2);
        bus.issue_rd    = 5'(rd);
        bus.issue_rd_we = we;
    endtask

    task automatic wb(input int rd);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'(rd);
    endtask

    task automatic test_reset();
        idle();
        bus.drain_req = 1'b0;
        reset = 1'b1;
        #13;
        reset = 1'b0;
        tick();
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL rst_flags got %h want 0", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL rst_cnt got %0d want 0", bus.outstanding);
        else n_pass++;
        n_total++;
        if (bus.wb_err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.wb_err);
        else n_pass++;
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.drain_done);
        else n_pass++;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.issue_ready);
        else n_pass++;
    endtask

    task automatic test_raw();
        issue(0, 0, 5, 1);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL raw_first_ready got %b want 1", bus.issue_ready);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.busy_flags !== 32'h20) $display("FAIL raw_flags got %h want 20", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd1) $display("FAIL raw_cnt got %0d want 1", bus.outstanding);
        else n_pass++;
        issue(5, 0, 0, 0);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL raw_stall got %b want 0", bus.issue_ready);
        else n_pass++;
        tick();
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL raw_stall2 got %b want 0", bus.issue_ready);
        else n_pass++;
        wb(5);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL raw_bypass got %b want 1", bus.issue_ready);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL raw_clear got %h want 0", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL raw_cnt0 got %0d want 0", bus.outstanding);
        else n_pass++;
    endtask

    task automatic test_hazards();
        issue(0, 0, 6, 1);
        tick();
        issue(0, 6, 0, 0);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL rs2_stall got %b want 0", bus.issue_ready);
        else n_pass++;
        issue(0, 0, 6, 1);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL waw_stall got %b want 0", bus.issue_ready);
        else n_pass++;
        issue(0, 0, 6, 0);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL rd_nowe_ready got %b want 1", bus.issue_ready);
        else n_pass++;
        idle();
        wb(6);
        tick();
        idle();
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL haz_clear got %h want 0", bus.busy_flags);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        issue(0, 0, 0, 1);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", bus.issue_ready);
        else n_pass++;
        tick();
        issue(0, 0, 0, 1);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL r0_ready2 got %b want 1", bus.issue_ready);
        else n_pass++;
        tick();
        idle();
        wb(0);
        tick();
        idle();
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL r0_flags got %h want 0", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL r0_cnt got %0d want 0", bus.outstanding);
        else n_pass++;
        n_total++;
        if (bus.wb_err !== 1'b0) $display("FAIL r0_err got %b want 0", bus.wb_err);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        issue(0, 0, 7, 1);
        tick();
        issue(0, 0, 7, 1);
        wb(7);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL same_ready got %b want 1", bus.issue_ready);
        else n_pass++;
        tick();
        idle();
        n_total++;
        if (bus.busy_flags !== 32'h80) $display("FAIL same_flags got %h want 80", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd1) $display("FAIL same_cnt got %0d want 1", bus.outstanding);
        else n_pass++;
        wb(7);
        tick();
        idle();
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL same_cnt0 got %0d want 0", bus.outstanding);
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int r = 1; r <= 3; r++) begin
            issue(0, 0, r, 1);
            tick();
        end
        idle();
        n_total++;
        if (bus.busy_flags !== 32'hE) $display("FAIL drn_flags got %h want e", bus.busy_flags);
        else n_pass++;
        bus.drain_req = 1'b1;
        tick();
        issue(0, 0, 20, 1);
        #1;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL drn_block got %b want 0", bus.issue_ready);
        else n_pass++;
        wb(2);
        tick();
        wb(1);
        tick();
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL drn_early got %b want 0", bus.drain_done);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd1) $display("FAIL drn_cnt1 got %0d want 1", bus.outstanding);
        else n_pass++;
        wb(3);
        #1;
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL drn_wbcyc got %b want 0", bus.drain_done);
        else n_pass++;
        tick();
        bus.wb_valid = 1'b0;
        n_total++;
        if (bus.drain_done !== 1'b1) $display("FAIL drn_done got %b want 1", bus.drain_done);
        else n_pass++;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL drn_done_rdy got %b want 0", bus.issue_ready);
        else n_pass++;
        bus.drain_req = 1'b0;
        #1;
        n_total++;
        if (bus.drain_done !== 1'b1) $display("FAIL drn_hold got %b want 1", bus.drain_done);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL drn_drop got %b want 0", bus.drain_done);
        else n_pass++;
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL drn_run got %b want 1", bus.issue_ready);
        else n_pass++;
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL drn_noissue got %h want 0", bus.busy_flags);
        else n_pass++;
    endtask

    task automatic test_abort();
        issue(0, 0, 4, 1);
        tick();
        idle();
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        tick();
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL abort_run got %b want 1", bus.issue_ready);
        else n_pass++;
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.drain_done);
        else n_pass++;
        wb(4);
        tick();
        idle();
    endtask

    task automatic test_wb_err();
        wb(9);
        tick();
        idle();
        n_total++;
        if (bus.wb_err !== 1'b1) $display("FAIL err_set got %b want 1", bus.wb_err);
        else n_pass++;
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL err_flags got %h want 0", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL err_cnt got %0d want 0", bus.outstanding);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (bus.wb_err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.wb_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        for (int r = 1; r <= 4; r++) begin
            issue(0, 0, r, 1);
            tick();
        end
        idle();
        bus.drain_req = 1'b1;
        tick();
        n_total++;
        if (bus.outstanding !== 6'd4) $display("FAIL rmd_cnt4 got %0d want 4", bus.outstanding);
        else n_pass++;
        n_total++;
        if (bus.issue_ready !== 1'b0) $display("FAIL rmd_drain got %b want 0", bus.issue_ready);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.busy_flags !== 32'h0) $display("FAIL rmd_flags got %h want 0", bus.busy_flags);
        else n_pass++;
        n_total++;
        if (bus.outstanding !== 6'd0) $display("FAIL rmd_cnt got %0d want 0", bus.outstanding);
        else n_pass++;
        n_total++;
        if (bus.wb_err !== 1'b0) $display("FAIL rmd_err got %b want 0", bus.wb_err);
        else n_pass++;
        n_total++;
        if (bus.drain_done !== 1'b0) $display("FAIL rmd_done got %b want 0", bus.drain_done);
        else n_pass++;
        bus.drain_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_total++;
        if (bus.issue_ready !== 1'b1) $display("FAIL rmd_ready got %b want 1", bus.issue_ready);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        idle();
        bus.drain_req = 1'b0;
        test_reset();
        test_raw();
        test_hazards();
        test_zero_reg();
        test_same_cycle();
        test_drain();
        test_abort();
        test_wb_err();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
